mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_pkg.sv | 33 +++
 rtl/cond_negate.sv | 12 +
 rtl/mult_div_unit.sv | 185 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Op encodings, FSM state type and small decode helpers shared by the
// multiply/divide unit.
package mult_div_pkg;

  localparam logic [1:0] OPC_MULT  = 2'b00;
  localparam logic [1:0] OPC_MULTU = 2'b01;
  localparam logic [1:0] OPC_DIV   = 2'b10;
  localparam logic [1:0] OPC_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    OP_MULT  = OPC_MULT,
    OP_MULTU = OPC_MULTU,
    OP_DIV   = OPC_DIV,
    OP_DIVU  = OPC_DIVU
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIXUP,
    ST_DONE
  } state_e;

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/cond_negate.sv
// Combinational two's-complement conditional negate: o_val = i_neg ? -i_val : i_val.
module cond_negate #(
  parameter int W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Macro MULT_DIV_UNIT_DIVIDE_EN compiles in the divide datapath; without it DIV/DIVU raise op_err.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] oper_A,
  input  logic [WIDTH-1:0] oper_B,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero,
  output logic             op_err,
  output logic [CW-1:0]    iter_count
);
  import mult_div_pkg::*;

  state_e             r_state;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_neg_res;
  logic               r_busy;
  logic               r_done;
  logic               r_div_zero;
  logic [CW-1:0]      r_iter;

  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic               w_last;

  assign w_signed = op_is_signed(op_e'(op));
  assign w_a_neg  = w_signed & oper_A[WIDTH-1];
  assign w_b_neg  = w_signed & oper_B[WIDTH-1];

  cond_negate #(.W(WIDTH)) u_mag_a (.i_neg(w_a_neg), .i_val(oper_A), .o_val(w_a_mag));
  cond_negate #(.W(WIDTH)) u_mag_b (.i_neg(w_b_neg), .i_val(oper_B), .o_val(w_b_mag));

  // r_prod = {accumulator, multiplier}; the multiplier shifts out as the product shifts in
  assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
  assign w_mul_next = r_prod[0] ? {w_mul_sum, r_prod[WIDTH-1:1]}
                                : {1'b0, r_prod[2*WIDTH-1:1]};
  assign w_last     = (r_iter == CW'(WIDTH - 1));

  cond_negate #(.W(2*WIDTH)) u_fix_prod (.i_neg(r_neg_res), .i_val(r_prod), .o_val(w_prod_fix));

`ifdef MULT_DIV_UNIT_DIVIDE_EN
  logic               r_neg_rem;
  logic               r_is_div;
  logic [WIDTH:0]     w_div_trial;
  logic [2*WIDTH-1:0] w_div_next;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  // r_prod = {remainder, dividend/quotient}; top W+1 bits are the shifted partial remainder
  assign w_div_trial = r_prod[2*WIDTH-1:WIDTH-1] - {1'b0, r_mcand};
  assign w_div_next  = w_div_trial[WIDTH] ? {r_prod[2*WIDTH-2:0], 1'b0}
                                          : {w_div_trial[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};

  cond_negate #(.W(WIDTH)) u_fix_quo (.i_neg(r_neg_res), .i_val(r_prod[WIDTH-1:0]), .o_val(w_quo_fix));
  cond_negate #(.W(WIDTH)) u_fix_rem (.i_neg(r_neg_rem), .i_val(r_prod[2*WIDTH-1:WIDTH]), .o_val(w_rem_fix));

  assign op_err = 1'b0;
`else
  logic r_op_err;
  assign op_err = r_op_err;
`endif

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_prod     <= '0;
      r_mcand    <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_neg_res  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_iter     <= '0;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
      r_neg_rem  <= 1'b0;
      r_is_div   <= 1'b0;
`else
      r_op_err   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_iter     <= '0;
            r_div_zero <= 1'b0;
            r_mcand    <= w_b_mag;
            r_prod     <= {{WIDTH{1'b0}}, w_a_mag};
            r_neg_res  <= w_a_neg ^ w_b_neg;
            r_busy     <= 1'b1;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
            r_neg_rem  <= w_a_neg;
            r_is_div   <= op_is_div(op_e'(op));
            if (!op_is_div(op_e'(op))) begin
              r_state <= ST_MUL;
            end else if (oper_B == '0) begin
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_div_zero <= 1'b1;
            end else begin
              r_state <= ST_DIV;
            end
`else
            if (!op_is_div(op_e'(op))) begin
              r_state  <= ST_MUL;
              r_op_err <= 1'b0;
            end else begin
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_op_err <= 1'b1;
            end
`endif
          end else begin
            if (wr_hi) r_hi <= wr_data;
            if (wr_lo) r_lo <= wr_data;
          end
        end
        ST_MUL: begin
          r_prod <= w_mul_next;
          r_iter <= r_iter + CW'(1);
          if (w_last) r_state <= ST_FIXUP;
        end
`ifdef MULT_DIV_UNIT_DIVIDE_EN
        ST_DIV: begin
          r_prod <= w_div_next;
          r_iter <= r_iter + CW'(1);
          if (w_last) r_state <= ST_FIXUP;
        end
`endif
        ST_FIXUP: begin
`ifdef MULT_DIV_UNIT_DIVIDE_EN
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else
`endif
          begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign hi         = r_hi;
  assign lo         = r_lo;
  assign div_zero   = r_div_zero;
  assign iter_count = r_iter;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit (WIDTH=32); honours MULT_DIV_UNIT_DIVIDE_EN like the design.
module tb_mult_div_unit;

  localparam int W  = 32;
  localparam int CW = $clog2(W) + 1;

  logic          Clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  oper_A = '0;
  logic [W-1:0]  oper_B = '0;
  logic          wr_hi = 1'b0;
  logic          wr_lo = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          div_zero;
  logic          op_err;
  logic [CW-1:0] iter_count;

  mult_div_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .reset(reset), .start(start), .op(op),
    .oper_A(oper_A), .oper_B(oper_B),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_zero(div_zero), .op_err(op_err), .iter_count(iter_count)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    logic         oe;
    int           iter;
    int           lat;
    int           t0;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain arithmetic on 64-bit values, signed division truncating toward zero.
  function automatic exp_t model_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sb_, q, r;
    e.dz = 1'b0; e.oe = 1'b0; e.iter = W; e.lat = W + 2; e.t0 = 0;
    sa = $signed(a);
    sb_ = $signed(b);
    if (o[1] == 1'b0) begin
      if (o == 2'b00) p = sa * sb_;
      else            p = {32'h0, a} * {32'h0, b};
      m_hi = p[63:32];
      m_lo = p[31:0];
    end else begin
`ifdef MULT_DIV_UNIT_DIVIDE_EN
      if (b == 0) begin
        e.dz = 1'b1; e.iter = 0; e.lat = 1;
      end else begin
        if (o == 2'b11) begin
          sa = longint'({32'h0, a});
          sb_ = longint'({32'h0, b});
        end
        q = sa / sb_;
        r = sa % sb_;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
`else
      e.oe = 1'b1; e.iter = 0; e.lat = 1;
`endif
    end
    e.hi = m_hi;
    e.lo = m_lo;
    return e;
  endfunction

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge Clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn t0=%0d hi=0x%08h lo=0x%08h dz=%0b oe=%0b", e.t0, hi, lo, div_zero, op_err);
        chk("done_latency", 64'(cyc - e.t0), 64'(e.lat));
        chk("hi", 64'(hi), 64'(e.hi));
        chk("lo", 64'(lo), 64'(e.lo));
        chk("div_zero", 64'(div_zero), 64'(e.dz));
        chk("op_err", 64'(op_err), 64'(e.oe));
        chk("iter_count", 64'(iter_count), 64'(e.iter));
        chk("busy_in_done", 64'(busy), 64'(1));
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) chk("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit with_wr, output int t0);
    exp_t e;
    wait_idle();
    start = 1'b1; op = o; oper_A = a; oper_B = b;
    if (with_wr) begin
      wr_hi = 1'b1; wr_lo = 1'b1; wr_data = $urandom;
    end
    e = model_op(o, a, b);
    e.t0 = cyc;
    t0 = cyc;
    sb.push_back(e);
    tick();
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
  endtask

  task automatic do_write(input bit h, input bit l, input logic [W-1:0] d);
    wait_idle();
    wr_hi = h; wr_lo = l; wr_data = d;
    if (h) m_hi = d;
    if (l) m_lo = d;
    tick();
    wr_hi = 1'b0; wr_lo = 1'b0;
    chk("wr_hi_val", 64'(hi), 64'(m_hi));
    chk("wr_lo_val", 64'(lo), 64'(m_lo));
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int t0;
    int seen;
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bit seen_done;
    logic [1:0] rop;

    repeat (3) tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_hi", 64'(hi), 0);
    chk("rst_lo", 64'(lo), 0);
    chk("rst_div_zero", 64'(div_zero), 0);
    chk("rst_op_err", 64'(op_err), 0);
    chk("rst_iter", 64'(iter_count), 0);
    reset = 1'b0;
    tick();

    do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, t0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, t0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, t0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, t0);

    do_write(1'b1, 1'b0, 32'h1234);
    do_write(1'b0, 1'b1, 32'h5678);
    do_op(2'b11, 32'd7, 32'd0, 1'b0, t0);
    wait_idle();
    repeat (3) tick();
`ifdef MULT_DIV_UNIT_DIVIDE_EN
    chk("div_zero_sticky", 64'(div_zero), 1);
`else
    chk("op_err_sticky", 64'(op_err), 1);
`endif
    // The next accepted start clears the sticky flags; start also beats a same-cycle write.
    do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b1, t0);
    chk("dz_cleared", 64'(div_zero), 0);
    chk("oe_cleared", 64'(op_err), 0);

    // Start and a LO write while busy must both be ignored.
    while (cyc < t0 + 10) tick();
    chk("iter_mid_mul", 64'(iter_count), 9);
    start = 1'b1; op = 2'b01; oper_A = $urandom; oper_B = $urandom;
    wr_lo = 1'b1; wr_data = 32'hDEAD_BEEF;
    tick();
    start = 1'b0; wr_lo = 1'b0;

    // Reset in cycle 15 of an operation discards it entirely.
`ifdef MULT_DIV_UNIT_DIVIDE_EN
    rop = 2'b10;
`else
    rop = 2'b00;
`endif
    do_op(rop, 32'hFFFF_0123, 32'd3, 1'b0, t0);
    while (cyc < t0 + 15) tick();
    reset = 1'b1;
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    tick();
    reset = 1'b0;
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_hi", 64'(hi), 0);
    chk("midrst_lo", 64'(lo), 0);
    chk("midrst_iter", 64'(iter_count), 0);
    seen_done = 1'b0;
    repeat (40) begin
      if (done) seen_done = 1'b1;
      tick();
    end
    chk("no_done_after_reset", 64'(seen_done), 0);

    // Unsupported-op path in the default build: DIV gives op_err and done in cycle 1.
    do_op(2'b10, 32'd100, 32'd7, 1'b0, t0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = pick_val();
      b = pick_val();
      if ($urandom_range(0, 4) == 0) do_write($urandom_range(0, 1) == 1, 1'b1, $urandom);
      do_op(2'($urandom_range(0, 3)), a, b, $urandom_range(0, 5) == 0, t0);
    end

    wait_idle();
    repeat (3) tick();
    chk("scoreboard_drained", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
